// File: rtl/icache_responder.sv
// Direct-mapped, one-word-line instruction cache between the fetch stage and the memory controller.
// Hits answer one cycle after the request; misses fetch over a req/ack handshake, fill the line, then respond.
module icache_responder #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        rd_ena,
  input  logic [31:0] pc,
  output logic        instr_rdy,
  output logic [31:0] instr_out,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_ack,
  input  logic [31:0] mc_data
);

  localparam int NUM_LINES = 2 ** INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic                    cancel_q, cancel_d;
  logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;
  logic                    instr_rdy_q, instr_rdy_d;
  logic [31:0]             instr_out_q, instr_out_d;
  logic                    mc_req_q, mc_req_d;
  logic [31:0]             mc_addr_q, mc_addr_d;

  logic [31:0]             data_q [NUM_LINES];
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic                    fill_en;

  logic [INDEX_BITS-1:0]   pc_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [31:0]             pc_aligned;
  logic                    hit;

  assign pc_idx     = pc[INDEX_BITS+1:2];
  assign pc_tag     = pc[31:INDEX_BITS+2];
  assign pc_aligned = pc & ~32'h3;
  assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // NOTE: every always_comb output gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cancel_d    = cancel_q;
    miss_idx_d  = miss_idx_q;
    miss_tag_d  = miss_tag_q;
    instr_rdy_d = instr_rdy_q;
    instr_out_d = instr_out_q;
    mc_req_d    = mc_req_q;
    mc_addr_d   = mc_addr_q;
    fill_en     = 1'b0;

    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          instr_rdy_d = 1'b0;
          if (rd_ena) begin
            if (hit) begin
              instr_rdy_d = !clear;
              instr_out_d = data_q[pc_idx];
            end else begin
              mc_req_d   = 1'b1;
              mc_addr_d  = pc_aligned;
              miss_idx_d = pc_idx;
              miss_tag_d = pc_tag;
              cancel_d   = 1'b0;
              state_d    = MISS;
            end
          end
        end
        MISS: begin
          instr_rdy_d = 1'b0;
          if (clear) cancel_d = 1'b1;
          // The fill always lands, even when the response is suppressed.
          if (mc_ack) begin
            fill_en              = 1'b1;
            valid_d[miss_idx_q]  = 1'b1;
            mc_req_d             = 1'b0;
            instr_out_d          = mc_data;
            instr_rdy_d          = !(cancel_q || clear);
            state_d              = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cancel_q    <= 1'b0;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      instr_rdy_q <= 1'b0;
      instr_out_q <= '0;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cancel_q    <= cancel_d;
      miss_idx_q  <= miss_idx_d;
      miss_tag_q  <= miss_tag_d;
      instr_rdy_q <= instr_rdy_d;
      instr_out_q <= instr_out_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
    end
  end

  // NOTE: data and tag arrays carry no reset; valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[miss_idx_q] <= mc_data;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

  assign instr_rdy = instr_rdy_q;
  assign instr_out = instr_out_q;
  assign mc_req    = mc_req_q;
  assign mc_addr   = mc_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: misses, hits, eviction, clear, stall and async reset.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        rd_ena = 1'b0;
  logic [31:0] pc = '0;
  logic        instr_rdy;
  logic [31:0] instr_out;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_ack = 1'b0;
  logic [31:0] mc_data = '0;

  int passes = 0;
  int total  = 0;

  icache_responder #(.INDEX_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .rd_ena    (rd_ena),
    .pc        (pc),
    .instr_rdy (instr_rdy),
    .instr_out (instr_out),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_ack    (mc_ack),
    .mc_data   (mc_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a miss on addr and complete it with one ack carrying data.
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] data);
    rd_ena = 1'b1;
    pc     = addr;
    step();
    rd_ena = 1'b0;
    check({tag, "_req"}, {31'd0, mc_req}, 32'd1);
    check({tag, "_addr"}, mc_addr, addr);
    mc_ack  = 1'b1;
    mc_data = data;
    step();
    mc_ack = 1'b0;
    check({tag, "_rdy"}, {31'd0, instr_rdy}, 32'd1);
    check({tag, "_data"}, instr_out, data);
  endtask

  task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    rd_ena = 1'b1;
    pc     = addr;
    step();
    rd_ena = 1'b0;
    check({tag, "_rdy"}, {31'd0, instr_rdy}, 32'd1);
    check({tag, "_data"}, instr_out, data);
    check({tag, "_noreq"}, {31'd0, mc_req}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rdy", {31'd0, instr_rdy}, 32'd0);
    check("rst_out", instr_out, 32'd0);
    check("rst_req", {31'd0, mc_req}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    rst = 1'b0;

    // Cold miss on 0x4, ack three cycles after the request appears
    rd_ena = 1'b1;
    pc     = 32'h4;
    step();
    rd_ena = 1'b0;
    check("cold_req", {31'd0, mc_req}, 32'd1);
    check("cold_addr", mc_addr, 32'h4);
    step();
    step();
    check("cold_wait_rdy", {31'd0, instr_rdy}, 32'd0);
    check("cold_wait_addr", mc_addr, 32'h4);
    mc_ack  = 1'b1;
    mc_data = 32'h00A0_0093;
    step();
    mc_ack = 1'b0;
    check("cold_rdy", {31'd0, instr_rdy}, 32'd1);
    check("cold_data", instr_out, 32'h00A0_0093);
    check("cold_req_drop", {31'd0, mc_req}, 32'd0);
    step();
    check("cold_pulse_end", {31'd0, instr_rdy}, 32'd0);
    hit("rehit4", 32'h4, 32'h00A0_0093);

    // Streaming hits over 0x0, 0x4, 0x8
    do_miss("fill0", 32'h0, 32'h1111_0000);
    do_miss("fill8", 32'h8, 32'h3333_0008);
    rd_ena = 1'b1;
    pc     = 32'h0;
    step();
    check("s0_rdy", {31'd0, instr_rdy}, 32'd1);
    check("s0_data", instr_out, 32'h1111_0000);
    pc = 32'h4;
    step();
    check("s1_rdy", {31'd0, instr_rdy}, 32'd1);
    check("s1_data", instr_out, 32'h00A0_0093);
    pc = 32'h8;
    step();
    check("s2_rdy", {31'd0, instr_rdy}, 32'd1);
    check("s2_data", instr_out, 32'h3333_0008);
    rd_ena = 1'b0;
    step();
    check("s_idle", {31'd0, instr_rdy}, 32'd0);

    // Unsolicited ack in IDLE is ignored
    mc_ack  = 1'b1;
    mc_data = 32'hDEAD_BEEF;
    step();
    mc_ack = 1'b0;
    check("unsol_rdy", {31'd0, instr_rdy}, 32'd0);
    check("unsol_req", {31'd0, mc_req}, 32'd0);

    // Conflict eviction: 0x400 shares index 0 with 0x0
    do_miss("evict400", 32'h400, 32'h4444_0400);
    do_miss("refill0", 32'h0, 32'h1111_0000);

    // clear one cycle before the ack suppresses the response, fill still lands
    rd_ena = 1'b1;
    pc     = 32'h10;
    step();
    rd_ena = 1'b0;
    check("clr_req", {31'd0, mc_req}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_req", {31'd0, mc_req}, 32'd1);
    mc_ack  = 1'b1;
    mc_data = 32'h5555_0010;
    step();
    mc_ack = 1'b0;
    check("clr_no_rdy", {31'd0, instr_rdy}, 32'd0);
    check("clr_req_drop", {31'd0, mc_req}, 32'd0);
    hit("clr_hit10", 32'h10, 32'h5555_0010);

    // clear together with the ack: fill written, no response
    rd_ena = 1'b1;
    pc     = 32'h14;
    step();
    rd_ena  = 1'b0;
    clear   = 1'b1;
    mc_ack  = 1'b1;
    mc_data = 32'h6666_0014;
    step();
    clear  = 1'b0;
    mc_ack = 1'b0;
    check("clrack_no_rdy", {31'd0, instr_rdy}, 32'd0);
    hit("clrack_hit14", 32'h14, 32'h6666_0014);

    // clear in IDLE blocks a hit response
    rd_ena = 1'b1;
    pc     = 32'h10;
    clear  = 1'b1;
    step();
    rd_ena = 1'b0;
    clear  = 1'b0;
    check("idle_clr_rdy", {31'd0, instr_rdy}, 32'd0);
    hit("idle_clr_still_valid", 32'h10, 32'h5555_0010);

    // rdy stall for four cycles during MISS
    rd_ena = 1'b1;
    pc     = 32'h20;
    step();
    rd_ena = 1'b0;
    rdy    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_ena = 1'b1;
      pc     = 32'h4;
      step();
      check("stall_req", {31'd0, mc_req}, 32'd1);
      check("stall_addr", mc_addr, 32'h20);
      check("stall_rdy", {31'd0, instr_rdy}, 32'd0);
    end
    rd_ena  = 1'b0;
    rdy     = 1'b1;
    mc_ack  = 1'b1;
    mc_data = 32'h7777_0020;
    step();
    mc_ack = 1'b0;
    check("stall_resume_rdy", {31'd0, instr_rdy}, 32'd1);
    check("stall_resume_data", instr_out, 32'h7777_0020);

    // Async reset mid-miss
    rd_ena = 1'b1;
    pc     = 32'h24;
    step();
    rd_ena = 1'b0;
    check("arst_pre_req", {31'd0, mc_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, mc_req}, 32'd0);
    check("arst_rdy", {31'd0, instr_rdy}, 32'd0);
    check("arst_addr", mc_addr, 32'd0);
    #2 rst = 1'b0;
    rd_ena = 1'b1;
    pc     = 32'h4;
    step();
    rd_ena = 1'b0;
    check("arst_miss_req", {31'd0, mc_req}, 32'd1);
    check("arst_miss_rdy", {31'd0, instr_rdy}, 32'd0);
    check("arst_miss_addr", mc_addr, 32'h4);
    mc_ack  = 1'b1;
    mc_data = 32'h00A0_0093;
    step();
    mc_ack = 1'b0;
    check("arst_fill_rdy", {31'd0, instr_rdy}, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that answers the instruction fetcher's read requests.
- Serves the fetcher's (rd_ena, pc) request port and returns instr_rdy with the 32-bit instruction.
- On a miss, fetches the word from the memory controller over a word-wide req/ack handshake, fills the line, then responds.
- Sits between the fetch stage and the memory controller.

Parameters:
INDEX_BITS, 8, line index width; the cache holds 2^INDEX_BITS one-word lines.
TAG_BITS, 30-INDEX_BITS, tag width (address bits [31:2+INDEX_BITS]).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
rdy  input  1  global ready; low = pause, all state holds.
clear  input  1  rollback/misprediction; cancels any pending response.
rd_ena  input  1  fetch request valid.
pc  input  32  fetch address; bits [1:0] ignored.
instr_rdy  output  1  one-cycle pulse: instr_out is valid.
instr_out  output  32  returned instruction.
mc_req  output  1  miss request to the memory controller; held until mc_ack.
mc_addr  output  32  word-aligned miss address ({pc[31:2],2'b00}).
mc_ack  input  1  one-cycle pulse: mc_data is valid.
mc_data  input  32  fetched word.

Behaviour:
- Reset (async, rst=1): all valid bits cleared; state=IDLE; instr_rdy=0, instr_out=0, mc_req=0, mc_addr=0. Data and tag arrays are not reset.
- rdy=0: nothing updates; outputs hold their registered values. The memory controller never pulses mc_ack while rdy=0.
- FSM states: IDLE, MISS. Transitions below are evaluated at posedge clk with rdy=1 and rst=0.
- IDLE, rd_ena=0: instr_rdy<=0.
- IDLE, rd_ena=1, hit (valid[idx] and tag[idx]==pc tag): instr_rdy<=1, instr_out<=data[idx]. Latency is 1 cycle. Back-to-back hits give 1 response per cycle.
- IDLE, rd_ena=1, miss:
  - instr_rdy<=0; mc_req<=1; mc_addr<=aligned pc.
  - Latch index and tag into miss_idx/miss_tag; cancel<=0; go to MISS.
- MISS:
  - rd_ena is ignored. The fetcher re-presents its pc after the response.
  - mc_req and mc_addr hold stable until mc_ack.
- MISS, mc_ack=1:
  - data[miss_idx]<=mc_data; tag<=miss_tag; valid<=1; mc_req<=0; go to IDLE.
  - instr_out<=mc_data; instr_rdy<=~(cancel|clear).
  - The fill always completes, even when cancelled.
- clear:
  - In IDLE, clear=1 forces instr_rdy<=0 regardless of hit. It does not invalidate any line.
  - In MISS, clear=1 sets cancel<=1, suppressing that miss's response.
  - clear and mc_ack in the same cycle: fill is written, no response.
- Miss latency: 1 (request issue) + memory latency + 0 (response is registered on the mc_ack edge).
- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. Address wrap at 0xFFFFFFFC needs no special handling.
- Reset asserted mid-miss: returns to IDLE, mc_req drops immediately, all lines are invalid.
- The memory controller must not pulse mc_ack without mc_req. An unsolicited ack in IDLE is ignored.
- instr_rdy never stays high for two cycles for one request. No response is issued without an accepted request.

Test Plan:
- Cold miss then hit:
  - After reset, rd_ena=1, pc=0x00000004 -> mc_req=1, mc_addr=0x4 next cycle.
  - Ack 3 cycles later with mc_data=0x00A00093 -> instr_rdy pulse, instr_out=0x00A00093.
  - Re-request 0x4 -> instr_rdy 1 cycle later with the same data, mc_req stays 0.
- Streaming hits: preload 0x0, 0x4, 0x8; rd_ena held with pc stepping each cycle -> three consecutive instr_rdy pulses with the matching data.
- Conflict eviction (INDEX_BITS=8):
  - Fill 0x0000, then request 0x0400 (same index) -> miss and refill.
  - Request 0x0000 again -> miss again.
- clear during miss:
  - Miss on 0x10; clear=1 one cycle before mc_ack -> no instr_rdy.
  - Subsequent 0x10 request hits with 1-cycle latency.
- rdy stall: hold rdy=0 for 4 cycles during MISS -> mc_req/mc_addr stable, no state change; resumes correctly after rdy=1.
- Async reset mid-miss: assert rst between edges -> mc_req=0 and instr_rdy=0 immediately; the prior hit address now misses.
